// File: rtl/lcd_arb_pkg.sv
// Shared types and constants for the LCD write arbiter.
// Holds FSM state and source encodings, default sizes and the character width.
package lcd_arb_pkg;

    localparam int CHAR_W    = 8;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_GAP   = 2000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    typedef enum logic {
        SRC_PS2 = 1'b0,
        SRC_CPU = 1'b1
    } src_t;

endpackage

// File: rtl/char_fifo.sv
// Small character FIFO, DEPTH x CHAR_W, synchronous push/pop, async reset.
// Ports: push_i/data_i in, pop_i/data_o out (head), full, empty, count, drop_o.
module char_fifo
    import lcd_arb_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [CHAR_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [CHAR_W-1:0]        data_o,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_o
);

    localparam int AW = $clog2(DEPTH);

    logic [CHAR_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q;
    logic [AW-1:0]     rd_q;
    logic [AW:0]       cnt_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    // Fullness is judged before any same-cycle pop, so a pop never rescues a push.
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty;
    assign drop_o  = push_i && full;
    assign data_o  = mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shares the LCD character-write port between the PS2 keyboard and the CPU.
// In: clock, resetn, ps2 key/char, cpu write/data, ovf_clear. Out: lcd write, full/ovf/busy.
module lcd_write_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int GAP   = DEF_GAP
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              ps2_key_pressed,
    input  logic [CHAR_W-1:0] ps2_out,
    input  logic              cpu_write_en,
    input  logic [31:0]       cpu_write_data,
    input  logic              ovf_clear,
    output logic              lcd_write_en,
    output logic [CHAR_W-1:0] lcd_write_data,
    output logic              cpu_full,
    output logic              ovf_ps2,
    output logic              ovf_cpu,
    output logic              busy
);

    localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

    state_t              state_q, state_d;
    src_t                last_q, last_d;
    src_t                gnt;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                wen_q, wen_d;
    logic [CHAR_W-1:0]   data_q, data_d;
    logic                ovf_ps2_q, ovf_ps2_d;
    logic                ovf_cpu_q, ovf_cpu_d;
    logic                ps2_key_q, ps2_prev_q;
    logic [CHAR_W-1:0]   ps2_data_q;
    logic                ps2_push;
    logic                pop_ps2, pop_cpu;
    logic [CHAR_W-1:0]   ps2_head, cpu_head;
    logic                ps2_full, ps2_empty, cpu_empty;
    logic                ps2_drop, cpu_drop;
    logic [$clog2(DEPTH):0] ps2_cnt, cpu_cnt;
    logic                unused_ok;

    // Edge detect works on the registered key, so the push lands one cycle
    // after the rise is sampled; the character is captured alongside it.
    assign ps2_push = ps2_key_q && !ps2_prev_q;

    char_fifo #(.DEPTH(DEPTH)) u_ps2_fifo (
        .clk_i  (clock),
        .rst_ni (resetn),
        .push_i (ps2_push),
        .data_i (ps2_data_q),
        .pop_i  (pop_ps2),
        .data_o (ps2_head),
        .full   (ps2_full),
        .empty  (ps2_empty),
        .count  (ps2_cnt),
        .drop_o (ps2_drop)
    );

    char_fifo #(.DEPTH(DEPTH)) u_cpu_fifo (
        .clk_i  (clock),
        .rst_ni (resetn),
        .push_i (cpu_write_en),
        .data_i (cpu_write_data[CHAR_W-1:0]),
        .pop_i  (pop_cpu),
        .data_o (cpu_head),
        .full   (cpu_full),
        .empty  (cpu_empty),
        .count  (cpu_cnt),
        .drop_o (cpu_drop)
    );

    assign unused_ok = ^{cpu_write_data[31:CHAR_W], ps2_cnt, cpu_cnt, ps2_full};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        wen_d   = 1'b0;
        data_d  = data_q;
        pop_ps2 = 1'b0;
        pop_cpu = 1'b0;
        gnt     = SRC_PS2;
        unique case (state_q)
            ST_IDLE: begin
                if (!ps2_empty || !cpu_empty) begin
                    if (ps2_empty) begin
                        gnt = SRC_CPU;
                    end else if (cpu_empty) begin
                        gnt = SRC_PS2;
                    end else begin
                        gnt = (last_q == SRC_PS2) ? SRC_CPU : SRC_PS2;
                    end
                    pop_ps2 = (gnt == SRC_PS2);
                    pop_cpu = (gnt == SRC_CPU);
                    data_d  = (gnt == SRC_PS2) ? ps2_head : cpu_head;
                    last_d  = gnt;
                    wen_d   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CW'(GAP - 1);
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A drop in the same cycle as a clear keeps the flag set.
    assign ovf_ps2_d = (ovf_ps2_q && !ovf_clear) || ps2_drop;
    assign ovf_cpu_d = (ovf_cpu_q && !ovf_clear) || cpu_drop;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            last_q     <= SRC_CPU;
            cnt_q      <= '0;
            wen_q      <= 1'b0;
            data_q     <= '0;
            ovf_ps2_q  <= 1'b0;
            ovf_cpu_q  <= 1'b0;
            ps2_key_q  <= 1'b0;
            ps2_prev_q <= 1'b0;
            ps2_data_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            wen_q      <= wen_d;
            data_q     <= data_d;
            ovf_ps2_q  <= ovf_ps2_d;
            ovf_cpu_q  <= ovf_cpu_d;
            ps2_key_q  <= ps2_key_pressed;
            ps2_prev_q <= ps2_key_q;
            ps2_data_q <= ps2_out;
        end
    end

    assign lcd_write_en   = wen_q;
    assign lcd_write_data = data_q;
    assign ovf_ps2        = ovf_ps2_q;
    assign ovf_cpu        = ovf_cpu_q;
    assign busy           = (state_q != ST_IDLE) || !ps2_empty || !cpu_empty;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Self-checking bench for lcd_write_arbiter: directed scenarios plus random
// traffic, all compared every cycle against a queue-based timing model.
module tb_lcd_write_arbiter;

    localparam int DEPTH = 4;
    localparam int GAP   = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        ps2_key_pressed = 1'b0;
    logic [7:0]  ps2_out = 8'h00;
    logic        cpu_write_en = 1'b0;
    logic [31:0] cpu_write_data = 32'h0;
    logic        ovf_clear = 1'b0;
    logic        lcd_write_en;
    logic [7:0]  lcd_write_data;
    logic        cpu_full, ovf_ps2, ovf_cpu, busy;

    int checks = 0;
    int errors = 0;

    lcd_write_arbiter #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clock           (clock),
        .resetn          (resetn),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_out         (ps2_out),
        .cpu_write_en    (cpu_write_en),
        .cpu_write_data  (cpu_write_data),
        .ovf_clear       (ovf_clear),
        .lcd_write_en    (lcd_write_en),
        .lcd_write_data  (lcd_write_data),
        .cpu_full        (cpu_full),
        .ovf_ps2         (ovf_ps2),
        .ovf_cpu         (ovf_cpu),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: two character queues, a round-robin pointer and the
    // earliest edge at which the next grant may happen (GAP+2 after a grant).
    logic [7:0] mq_ps2[$];
    logic [7:0] mq_cpu[$];
    int         mk, free_at, np, nc;
    logic       m_last, m_src, m_h1, m_h2, m_dp, m_dc;
    logic [7:0] m_d1;
    logic       e_wen, e_ovp, e_ovc;
    logic [7:0] e_data;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mq_ps2.delete();
            mq_cpu.delete();
            mk = 0; free_at = 0; m_last = 1'b1;
            m_h1 = 0; m_h2 = 0; m_d1 = 0;
            e_wen = 0; e_data = 0; e_ovp = 0; e_ovc = 0;
        end else begin
            mk++;
            np = mq_ps2.size();
            nc = mq_cpu.size();
            e_wen = 0;
            if (mk >= free_at && (np + nc) > 0) begin
                if (np == 0) m_src = 1'b1;
                else if (nc == 0) m_src = 1'b0;
                else m_src = !m_last;
                if (m_src) e_data = mq_cpu.pop_front();
                else e_data = mq_ps2.pop_front();
                m_last = m_src;
                e_wen = 1;
                free_at = mk + GAP + 2;
            end
            m_dc = 0;
            if (cpu_write_en) begin
                if (nc == DEPTH) m_dc = 1;
                else mq_cpu.push_back(cpu_write_data[7:0]);
            end
            m_dp = 0;
            if (m_h1 && !m_h2) begin
                if (np == DEPTH) m_dp = 1;
                else mq_ps2.push_back(m_d1);
            end
            e_ovc = (e_ovc && !ovf_clear) || m_dc;
            e_ovp = (e_ovp && !ovf_clear) || m_dp;
            m_h2 = m_h1;
            m_h1 = ps2_key_pressed;
            m_d1 = ps2_out;
        end
    end

    int         cyc = 0;
    logic [7:0] log_d[$];
    int         log_t[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        chk("wen", lcd_write_en, e_wen);
        chk("data", lcd_write_data, e_data);
        chk("cpu_full", cpu_full, mq_cpu.size() == DEPTH);
        chk("ovf_ps2", ovf_ps2, e_ovp);
        chk("ovf_cpu", ovf_cpu, e_ovc);
        chk("busy", busy,
            (mq_ps2.size() + mq_cpu.size() > 0) || (mk < free_at - 1));
        if (lcd_write_en) begin
            log_d.push_back(lcd_write_data);
            log_t.push_back(cyc + 1);
        end
    end

    function automatic logic [31:0] ld(input int i);
        return (i < log_d.size()) ? 32'(log_d[i]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] lt(input int i);
        return (i < log_t.size()) ? 32'(log_t[i]) : 32'hDEAD;
    endfunction

    task automatic step();
        @(negedge clock);
        #2;
    endtask

    task automatic clr_log();
        log_d.delete();
        log_t.delete();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        chk("idle_timeout", busy, 0);
        step();
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_wen"}, lcd_write_en, 0);
        chk({tag, "_data"}, lcd_write_data, 0);
        chk({tag, "_full"}, cpu_full, 0);
        chk({tag, "_ovp"}, ovf_ps2, 0);
        chk({tag, "_ovc"}, ovf_cpu, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // One CPU write starts a gap, then two chars per source queue behind it.
    task automatic load_backlog(input logic [7:0] first);
        cpu_write_en = 1; cpu_write_data = {24'h0, first}; step();
        cpu_write_en = 1; cpu_write_data = 32'h11;
        ps2_key_pressed = 1; ps2_out = 8'h01; step();
        cpu_write_en = 0; ps2_key_pressed = 0; step();
        cpu_write_en = 1; cpu_write_data = 32'h12;
        ps2_key_pressed = 1; ps2_out = 8'h02; step();
        cpu_write_en = 0; ps2_key_pressed = 0; step();
    endtask

    int t0;

    initial begin
        resetn = 0;
        repeat (3) step();
        all_zero("rst0");
        resetn = 1;
        repeat (3) step();

        // single CPU write
        clr_log();
        cpu_write_en = 1; cpu_write_data = 32'hFFFF_FF41;
        t0 = cyc + 1;
        step();
        cpu_write_en = 0;
        wait_idle();
        chk("cpu1_n", log_d.size(), 1);
        chk("cpu1_d", ld(0), 32'h41);
        chk("cpu1_lat", lt(0) - t0, 2);

        // PS2 key held high for 10 cycles
        clr_log();
        ps2_out = 8'h1C; ps2_key_pressed = 1;
        t0 = cyc + 1;
        repeat (10) step();
        ps2_key_pressed = 0;
        wait_idle();
        chk("ps2_n", log_d.size(), 1);
        chk("ps2_d", ld(0), 32'h1C);
        chk("ps2_lat", lt(0) - t0, 3);

        // reset mid-gap with two entries per FIFO
        clr_log();
        load_backlog(8'hA0);
        chk("pre_rst_busy", busy, 1);
        resetn = 0;
        #1;
        all_zero("rst1");
        step();
        step();
        resetn = 1;
        repeat (20) step();
        chk("rst_pulses", log_d.size(), 1);
        chk("rst_busy", busy, 0);

        // simultaneous arrival: key rise leads by one cycle to cover its edge register
        clr_log();
        ps2_out = 8'hAA; ps2_key_pressed = 1;
        step();
        cpu_write_en = 1; cpu_write_data = 32'h55;
        step();
        cpu_write_en = 0; ps2_key_pressed = 0;
        wait_idle();
        chk("sim_n", log_d.size(), 2);
        chk("sim_d0", ld(0), 32'hAA);
        chk("sim_d1", ld(1), 32'h55);
        chk("sim_gap", lt(1) - lt(0), GAP + 2);

        // backlog alternation
        clr_log();
        load_backlog(8'hEE);
        wait_idle();
        chk("bl_n", log_d.size(), 5);
        chk("bl_d1", ld(1), 32'h01);
        chk("bl_d2", ld(2), 32'h11);
        chk("bl_d3", ld(3), 32'h02);
        chk("bl_d4", ld(4), 32'h12);

        // CPU overflow while busy
        clr_log();
        ps2_out = 8'h77; ps2_key_pressed = 1; step();
        ps2_key_pressed = 0; step();
        for (int i = 0; i < 6; i++) begin
            cpu_write_en = 1; cpu_write_data = 32'(i);
            step();
        end
        cpu_write_en = 0;
        chk("ovf_full", cpu_full, 1);
        chk("ovf_cpu_set", ovf_cpu, 1);
        wait_idle();
        chk("ovf_n", log_d.size(), 5);
        for (int i = 0; i < 4; i++) chk("ovf_seq", ld(i + 1), 32'(i));
        ovf_clear = 1; step();
        ovf_clear = 0;
        chk("ovf_clr_cpu", ovf_cpu, 0);
        chk("ovf_clr_ps2", ovf_ps2, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cpu_write_en = ($urandom_range(0, 3) == 0);
            cpu_write_data = $urandom;
            ps2_out = 8'($urandom);
            if ($urandom_range(0, 2) == 0) ps2_key_pressed = !ps2_key_pressed;
            ovf_clear = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) begin
                resetn = 0;
                step();
                resetn = 1;
            end
            step();
        end
        cpu_write_en = 0; ps2_key_pressed = 0; ovf_clear = 0;
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_write_arbiter.md
# lcd_write_arbiter

Shares the single character-write port of the `lcd` controller between two producers: the PS2 keyboard interface (`ps2_key_pressed`/`ps2_out`) and the processor's LCD write port. Each source gets its own small character FIFO. Writes are granted round-robin and paced by a fixed inter-write gap, so the slow LCD controller is never overrun. The block sits in `skeleton` between `myps2`/`myprocessor` and `mylcd`, replacing the direct `ps2_out` connection.

## Interface
- `DEPTH`, 4: entries per source FIFO; power of two, ≥2.
- `GAP`, 2000: idle cycles after each issued write (40 µs at 50 MHz); ≥1.
- `clock`  in  1  system clock, all logic on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ps2_key_pressed`  in  1  keyboard strobe; a rising edge enqueues one character.
- `ps2_out`  in  8  keyboard character, sampled on the `ps2_key_pressed` rising edge.
- `cpu_write_en`  in  1  processor write strobe; each high cycle enqueues one character.
- `cpu_write_data`  in  32  processor data; bits [7:0] are the character, [31:8] are ignored.
- `ovf_clear`  in  1  clears both overflow flags.
- `lcd_write_en`  out  1  one-cycle write pulse to `lcd`, registered.
- `lcd_write_data`  out  8  character to `lcd`, registered; valid while `lcd_write_en` is high, held otherwise.
- `cpu_full`  out  1  processor FIFO holds DEPTH entries (combinational from count).
- `ovf_ps2`, `ovf_cpu`  out  1 each  sticky drop flags.
- `busy`  out  1  high when the FSM is not IDLE or either FIFO is non-empty.

## Operation
- **PS2 capture:** `ps2_key_pressed` is registered once. A rising edge (current=1, previous=0) pushes `ps2_out` into the PS2 FIFO. A level held high produces exactly one push.
- **CPU capture:** every cycle with `cpu_write_en`=1 pushes `cpu_write_data[7:0]`.
- **Push to a full FIFO:** the push is dropped, FIFO contents are unchanged, and the matching `ovf_*` flag is set. A pop in the same cycle does not rescue the push. No wrap-around corruption of pointers.
- **Overflow flags:** `ovf_clear` clears both flags. A new overflow in the same cycle as `ovf_clear` wins, so the flag stays set.
- **FSM, three states:**
  - IDLE: if any FIFO is non-empty, pick a source, pop its head into the `lcd_write_data` register, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `lcd_write_en`=1 for this cycle only. Load the gap counter with GAP-1 and go to GAP.
  - GAP: decrement the counter; go to IDLE when it reaches 0.
- **Round-robin:** `last_grant` register. If both FIFOs are non-empty, grant the source that is not `last_grant`. If only one is non-empty, grant it. `last_grant` updates on each grant and resets to CPU, so PS2 wins the first tie.
- **Ordering:** characters from each source leave in FIFO order. There is no ordering guarantee between the two sources.
- **Pushes during ISSUE/GAP** are accepted normally (subject to full).
- **Reset** (any time, including mid-gap):
  - State returns to IDLE; FIFOs are emptied.
  - Flags clear; `last_grant` is set to CPU.
  - `lcd_write_en`=0, `lcd_write_data`=8'h00, `cpu_full`=0, `busy`=0.
  - The PS2 edge register resets to 0, so a key held high through reset release produces one push.

## Timing
- CPU write sampled at edge N into an empty FIFO with the FSM in IDLE:
  - IDLE grants at edge N+1.
  - `lcd_write_en` is high in the cycle after edge N+1 (edge N+1 to N+2).
  - Latency is 2 cycles.
- PS2 path adds one cycle for the edge register, giving 3 cycles from the `ps2_key_pressed` rise to `lcd_write_en`.
- Backlogged issue: `lcd_write_en` pulses are exactly GAP+2 cycles apart (ISSUE + GAP cycles + IDLE).
- `cpu_full` reflects the count after the previous edge. The processor must not rely on same-cycle backpressure; a write while `cpu_full`=1 is dropped.
- Maximum sustained rate: one character per GAP+2 cycles, aggregate across both sources.

## Structure
- **Shared package `lcd_arb_pkg`:**
  - state encoding IDLE/ISSUE/GAP;
  - source encoding SRC_PS2=0, SRC_CPU=1;
  - default DEPTH and GAP constants;
  - `CHAR_W`=8.
- **Sub-module `char_fifo`:**
  - parameterised DEPTH × CHAR_W, instantiated twice;
  - synchronous push/pop;
  - ports `full`, `empty`, `count`;
  - asynchronous active-low reset;
  - a drop-on-full indication output.
- The top level holds the edge detector, round-robin, FSM, gap counter and flags.

## Test plan
- **Reset values:** assert `resetn`=0 mid-GAP with both FIFOs holding 2 entries → all outputs 0; after release, no `lcd_write_en` pulse and `busy`=0.
- **Single CPU write:** `cpu_write_en` high for one cycle with data 32'hFFFF_FF41, GAP=4 → one `lcd_write_en` pulse with 8'h41, 2 cycles after the sampling edge; `busy` falls after the GAP completes.
- **PS2 held level:** `ps2_key_pressed` high for 10 cycles with `ps2_out`=8'h1C → exactly one pulse carrying 8'h1C.
- **Simultaneous first requests:** PS2 8'hAA and CPU 8'h55 requested in the same cycle, GAP=4 → outputs AA then 55, pulses 6 cycles apart.
- **Backlog alternation:** PS2 queue 01,02 and CPU queue 11,12 → outputs 01,11,02,12.
- **CPU overflow:** 6 back-to-back CPU writes 0..5 with DEPTH=4 and the FSM busy in GAP → `cpu_full`=1 and `ovf_cpu`=1; output sequence 0,1,2,3 (4 and 5 dropped); `ovf_clear` then drops `ovf_cpu` to 0 while `ovf_ps2` stays 0.
